alu_issue_wb: RTL and testbench
===============================

// Module: alu_issue_wb
// PURPOSE
//  Issue/writeback stage wrapped around the combinational alu: buffers incoming 32-bit MIPS
//  instructions in a FIFO, owns the 2-entry register file (addr 0 = regA, addr 1 = regB),
//  drives alu.instruction/regA/regB, then captures result/flags and writes the result back.
//  Screens out unrecognised opcodes so the alu never sees them.
// PARAMETERS
//  DEPTH   4             instruction FIFO entries (power of 2, >=2)
//  INIT_A  32'h00000000  regA value after reset
//  INIT_B  32'h00000000  regB value after reset
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous reset, active low
//  in_valid     in   1   instruction offered
//  in_ready     out  1   FIFO can accept (count < DEPTH)
//  in_instr     in   32  instruction word
//  cfg_we       in   1   direct register write (preload)
//  cfg_addr     in   1   0 = regA, 1 = regB
//  cfg_data     in   32  preload value
//  alu_instr    out  32  to alu.instruction
//  alu_rega     out  32  to alu.regA
//  alu_regb     out  32  to alu.regB
//  alu_result   in   32  from alu.result
//  alu_flags    in   3   from alu.flags ([0] zero/branch, [1] less-than, [2] overflow)
//  out_valid    out  1   completed-instruction record valid
//  out_ready    in   1   consumer accepts record
//  out_result   out  32  value written back (or alu result if no writeback)
//  out_flags    out  3   captured alu flags
//  out_illegal  out  1   instruction was unrecognised, not executed
//  reg_a        out  32  current regA
//  reg_b        out  32  current regB
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO empty, in_ready=1, state IDLE, regA=INIT_A, regB=INIT_B.
//   out_valid/out_result/out_flags/out_illegal=0. Reset mid-instruction discards everything.
//  FIFO: push when in_valid&in_ready. in_ready depends only on count (no pass-through when full).
//   Pop happens at the end of EXEC. Pointers wrap modulo DEPTH.
//  alu_rega=regA, alu_regb=regB always. alu_instr=FIFO head in EXEC if legal, else 32'h0.
//  FSM:
//   IDLE: when FIFO non-empty -> EXEC.
//   EXEC (1 cycle, alu settles combinationally): on clk edge capture out_* and write back,
//    pop FIFO, set out_valid=1 -> RESP.
//   RESP: hold out_* stable while out_valid&!out_ready. On out_ready: out_valid=0 next cycle,
//    go to EXEC if FIFO non-empty, else IDLE. Peak throughput: 1 instr / 2 cycles.
//  Legal set = R-type funct {20,21,22,23,24,25,26,27,2A,2B,00,02,03,04,06,07};
//   opcodes {08,09,0A,0B,0C,0D,0E,04,05,23,2B}. Other: out_illegal=1, result/flags=0, no write.
//  Writeback destination:
//   R-type -> instr[15:11]; ALU-immediates (08,09,0A,0B,0C,0D,0E) -> instr[20:16];
//   beq/bne/lw/sw -> none (lw/sw only report address in out_result).
//  Writeback value: alu_result, except slt/sltu/slti/sltiu -> {31'b0, alu_flags[1]}.
//   add/addi/sub with flags[2]=1: no writeback (MIPS trap semantics); out_flags[2]=1.
//  Destination address >1: write suppressed silently. Address 0 is writable (regA is not zero).
//  cfg_we accepted any cycle. Same cycle, same address as writeback: writeback wins.
//  Consumed operands are those present during EXEC (a cfg write in EXEC takes effect after).
// TESTING
//  1. Reset, INIT_A=5, INIT_B=7; push add rd=0,rs=0,rt=1 (0x00012020 with rd field 0)
//     -> EXEC next-but-one cycle; out_result=12, regA=12, out_flags=0.
//  2. regA=0x7FFFFFFF, regB=1, add rd=1 -> out_flags=3'b100, regB unchanged (1).
//  3. regA=-3, slti rt=1,rs=0,imm=0 -> regB=1, out_flags[1]=1; sltiu same -> regB=0.
//  4. Push 0xFC000000 (opcode 3F) -> out_illegal=1, alu_instr stays 0, regs unchanged.
//  5. out_ready=0, push DEPTH+1 instrs -> in_ready=0 after DEPTH pushes (one in RESP),
//     out_* stable; release out_ready -> all retire in order, none lost/duplicated.
//  6. Assert rst_n=0 while in RESP with 3 queued -> out_valid=0, FIFO empty, regs=INIT next.

Source files
------------

// File: rtl/alu_issue_wb.sv
// Issue/writeback stage around a combinational ALU: instruction FIFO, 2-entry register file,
// opcode screening, and a valid/ready completion record with writeback of the ALU result.
module alu_issue_wb #(
  parameter int          DEPTH  = 4,
  parameter logic [31:0] INIT_A = 32'h0000_0000,
  parameter logic [31:0] INIT_B = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        cfg_we,
  input  logic        cfg_addr,
  input  logic [31:0] cfg_data,
  output logic [31:0] alu_instr,
  output logic [31:0] alu_rega,
  output logic [31:0] alu_regb,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags,
  output logic        out_illegal,
  output logic [31:0] reg_a,
  output logic [31:0] reg_b
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [31:0]       fifo_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic [31:0]       rega_q, rega_d, regb_q, regb_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_result_q, out_result_d;
  logic [2:0]        out_flags_q, out_flags_d;
  logic              out_illegal_q, out_illegal_d;

  logic        push, pop, fifo_nonempty;
  logic [31:0] head;
  logic [5:0]  opcode, funct;
  logic        legal, is_r, imm_wr, is_slt, can_trap, trap, dst_en, wb_en;
  logic [4:0]  dst_addr;
  logic [31:0] wb_val;

  assign fifo_nonempty = (count_q != '0);
  assign in_ready      = (count_q < (AW+1)'(DEPTH));
  assign push          = in_valid & in_ready;
  assign head          = fifo_q[rd_ptr_q];
  assign opcode        = head[31:26];
  assign funct         = head[5:0];

  // Decode of the FIFO head: legality, writeback destination and special cases.
  always_comb begin
    legal    = 1'b0;
    is_r     = 1'b0;
    imm_wr   = 1'b0;
    is_slt   = 1'b0;
    can_trap = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h22:                      begin legal = 1'b1; can_trap = 1'b1; end
          6'h2A, 6'h2B:                      begin legal = 1'b1; is_slt = 1'b1; end
          6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: legal = 1'b1;
          default:                           legal = 1'b0;
        endcase
        is_r = legal;
      end
      6'h08:                      begin legal = 1'b1; imm_wr = 1'b1; can_trap = 1'b1; end
      6'h0A, 6'h0B:               begin legal = 1'b1; imm_wr = 1'b1; is_slt = 1'b1; end
      6'h09, 6'h0C, 6'h0D, 6'h0E: begin legal = 1'b1; imm_wr = 1'b1; end
      6'h04, 6'h05, 6'h23, 6'h2B: legal = 1'b1;
      default:                    legal = 1'b0;
    endcase
  end

  assign dst_addr = is_r ? head[15:11] : head[20:16];
  assign dst_en   = is_r | imm_wr;
  assign wb_val   = is_slt ? {31'b0, alu_flags[1]} : alu_result;
  assign trap     = can_trap & alu_flags[2];
  // Destinations beyond the two physical registers are dropped without any indication.
  assign wb_en    = (state_q == EXEC) & legal & dst_en & ~trap & (dst_addr[4:1] == 4'd0);

  assign alu_instr = ((state_q == EXEC) && legal) ? head : 32'h0;
  assign alu_rega  = rega_q;
  assign alu_regb  = regb_q;

  // NOTE: every signal assigned in this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_flags_d   = out_flags_q;
    out_illegal_d = out_illegal_q;
    case (state_q)
      IDLE: if (fifo_nonempty) state_d = EXEC;
      EXEC: begin
        pop           = 1'b1;
        out_valid_d   = 1'b1;
        out_illegal_d = ~legal;
        out_flags_d   = legal ? alu_flags : 3'b000;
        if (!legal)               out_result_d = 32'h0;
        else if (dst_en && !trap) out_result_d = wb_val;
        else                      out_result_d = alu_result;
        state_d = RESP;
      end
      RESP: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = fifo_nonempty ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Writeback is applied after a same-address cfg write so it takes priority.
  always_comb begin
    rega_d = rega_q;
    regb_d = regb_q;
    if (cfg_we && !cfg_addr) rega_d = cfg_data;
    if (cfg_we &&  cfg_addr) regb_d = cfg_data;
    if (wb_en && !dst_addr[0]) rega_d = wb_val;
    if (wb_en &&  dst_addr[0]) regb_d = wb_val;
  end

  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rega_q        <= INIT_A;
      regb_q        <= INIT_B;
      out_valid_q   <= 1'b0;
      out_result_q  <= 32'h0;
      out_flags_q   <= 3'b000;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rega_q        <= rega_d;
      regb_q        <= regb_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_flags_q   <= out_flags_d;
      out_illegal_q <= out_illegal_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= in_instr;
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_flags   = out_flags_q;
  assign out_illegal = out_illegal_q;
  assign reg_a       = rega_q;
  assign reg_b       = regb_q;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Scoreboard bench for alu_issue_wb: a behavioural ALU drives the alu_* inputs and a
// sequential reference model predicts each completion record at push time.
module tb_alu_issue_wb;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] INIT_A = 32'd5;
  localparam logic [31:0] INIT_B = 32'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr;
  logic        cfg_we, cfg_addr;
  logic [31:0] cfg_data;
  logic [31:0] alu_instr, alu_rega, alu_regb, alu_result;
  logic [2:0]  alu_flags;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic        out_illegal;
  logic [31:0] reg_a, reg_b;

  alu_issue_wb #(.DEPTH(DEPTH), .INIT_A(INIT_A), .INIT_B(INIT_B)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .alu_instr(alu_instr), .alu_rega(alu_rega), .alu_regb(alu_regb),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_illegal(out_illegal),
    .reg_a(reg_a), .reg_b(reg_b)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] res; logic [2:0] flags; } alu_t;
  typedef struct { logic [31:0] res; logic [2:0] flags; logic ill; logic [31:0] ra, rb; } exp_t;

  int          n_tests = 0, n_fail = 0, n_retired = 0;
  exp_t        sb[$];
  logic [31:0] ma, mb;
  logic        rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic alu_t alu_model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    logic [31:0] simm, zimm, r;
    logic        lt, ov, isbr, br;
    alu_t        o;
    op = ins[31:26]; fn = ins[5:0]; sh = ins[10:6];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0, ins[15:0]};
    r = 32'h0; lt = 1'b0; ov = 1'b0; isbr = 1'b0; br = 1'b0;
    case (op)
      6'h00: case (fn)
        6'h20: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
        6'h21: r = a + b;
        6'h22: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
        6'h23: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2A: begin lt = $signed(a) < $signed(b); r = {31'b0, lt}; end
        6'h2B: begin lt = a < b; r = {31'b0, lt}; end
        6'h00: r = b << sh;
        6'h02: r = b >> sh;
        6'h03: r = $signed(b) >>> sh;
        6'h04: r = b << a[4:0];
        6'h06: r = b >> a[4:0];
        6'h07: r = $signed(b) >>> a[4:0];
        default: r = 32'h0;
      endcase
      6'h08: begin r = a + simm; ov = (a[31] == simm[31]) && (r[31] != a[31]); end
      6'h09: r = a + simm;
      6'h0A: begin lt = $signed(a) < $signed(simm); r = {31'b0, lt}; end
      6'h0B: begin lt = a < simm; r = {31'b0, lt}; end
      6'h0C: r = a & zimm;
      6'h0D: r = a | zimm;
      6'h0E: r = a ^ zimm;
      6'h04: begin isbr = 1'b1; br = (a == b); r = a - b; end
      6'h05: begin isbr = 1'b1; br = (a != b); r = a - b; end
      6'h23, 6'h2B: r = a + simm;
      default: r = 32'h0;
    endcase
    o.res   = r;
    o.flags = {ov, lt, isbr ? br : (r == 32'h0)};
    return o;
  endfunction

  alu_t alu_o;
  always_comb alu_o = alu_model(alu_instr, alu_rega, alu_regb);
  assign alu_result = alu_o.res;
  assign alu_flags  = alu_o.flags;

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Reference model: executes the instruction against the model registers and queues the record.
  task automatic model_step(input logic [31:0] ins);
    exp_t       e;
    alu_t       a;
    logic [5:0] op, fn;
    logic       ok, rdst, idst, slt, trp;
    logic [4:0] d;
    logic [31:0] v;
    op = ins[31:26]; fn = ins[5:0];
    ok   = (op == 6'h00) ? (fn inside {6'h20,6'h21,6'h22,6'h23,6'h24,6'h25,6'h26,6'h27,
                                       6'h2A,6'h2B,6'h00,6'h02,6'h03,6'h04,6'h06,6'h07})
                         : (op inside {6'h08,6'h09,6'h0A,6'h0B,6'h0C,6'h0D,6'h0E,6'h04,6'h05,6'h23,6'h2B});
    e.ill = !ok; e.res = 32'h0; e.flags = 3'b000;
    if (ok) begin
      a    = alu_model(ins, ma, mb);
      rdst = (op == 6'h00);
      idst = (op inside {6'h08,6'h09,6'h0A,6'h0B,6'h0C,6'h0D,6'h0E});
      slt  = (rdst && fn inside {6'h2A,6'h2B}) || (op inside {6'h0A,6'h0B});
      trp  = ((rdst && fn inside {6'h20,6'h22}) || op == 6'h08) && a.flags[2];
      d    = rdst ? ins[15:11] : ins[20:16];
      v    = slt ? {31'b0, a.flags[1]} : a.res;
      e.flags = a.flags;
      if ((rdst || idst) && !trp) begin
        e.res = v;
        if (d == 5'd0) ma = v;
        if (d == 5'd1) mb = v;
      end else e.res = a.res;
    end
    e.ra = ma; e.rb = mb;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_out", {31'b0, out_valid}, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        n_retired++;
        check("out_result",  out_result, e.res);
        check("out_flags",   {29'b0, out_flags}, {29'b0, e.flags});
        check("out_illegal", {31'b0, out_illegal}, {31'b0, e.ill});
        check("reg_a",       reg_a, e.ra);
        check("reg_b",       reg_b, e.rb);
      end
    end
  end

  // The ALU must never be presented an unrecognised instruction.
  always @(negedge clk) begin
    if (rst_n && alu_instr == 32'hFC00_0000) check("alu_instr_screened", alu_instr, 32'h0);
  end

  always @(posedge clk) if (rand_rdy) begin #1; out_ready = ($urandom_range(0, 2) != 0); end

  task automatic push(input logic [31:0] ins);
    int n = 0;
    model_step(ins);
    in_instr = ins;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) check("push_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic addr, input logic [31:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (addr) mb = data; else ma = data;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 1000) begin @(posedge clk); #1; n++; end
    check("drain_done", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int r0;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0;
    cfg_we = 1'b0; cfg_addr = 1'b0; cfg_data = '0; out_ready = 1'b1;
    ma = INIT_A; mb = INIT_B;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready}, 32'd1);
    check("rst_reg_a",     reg_a, INIT_A);
    check("rst_reg_b",     reg_b, INIT_B);
    check("rst_out_result", out_result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // add rd=0 rs=0 rt=1: 5+7
    push(rtype(5'd0, 5'd1, 5'd0, 5'd0, 6'h20));
    drain();
    check("t1_reg_a", reg_a, 32'd12);

    // signed overflow: no writeback, overflow flag set
    cfg_write(1'b0, 32'h7FFF_FFFF);
    cfg_write(1'b1, 32'd1);
    push(rtype(5'd0, 5'd1, 5'd1, 5'd0, 6'h20));
    drain();
    check("t2_reg_b", reg_b, 32'd1);

    // slti / sltiu with regA = -3
    cfg_write(1'b0, 32'hFFFF_FFFD);
    push(itype(6'h0A, 5'd0, 5'd1, 16'h0000));
    drain();
    check("t3_slti_reg_b", reg_b, 32'd1);
    push(itype(6'h0B, 5'd0, 5'd1, 16'h0000));
    drain();
    check("t3_sltiu_reg_b", reg_b, 32'd0);

    // unrecognised opcode, then lw/beq/rd>1 cases that must not write
    push(32'hFC00_0000);
    push(itype(6'h23, 5'd0, 5'd1, 16'h0010));
    push(itype(6'h04, 5'd0, 5'd1, 16'h0004));
    push(rtype(5'd0, 5'd1, 5'd3, 5'd0, 6'h21));
    drain();

    // back-pressure: DEPTH+1 instructions with the consumer stalled
    cfg_write(1'b0, 32'd0);
    out_ready = 1'b0;
    r0 = n_retired;
    for (int k = 1; k <= DEPTH + 1; k++) push(itype(6'h09, 5'd0, 5'd0, 16'(k)));
    check("t5_in_ready_full", {31'b0, in_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_hold_valid",  {31'b0, out_valid}, 32'd1);
    check("t5_hold_result", out_result, sb[0].res);
    check("t5_hold_reg_a",  reg_a, 32'd1);
    out_ready = 1'b1;
    drain();
    check("t5_retired", 32'(n_retired - r0), 32'(DEPTH + 1));
    check("t5_final_a", reg_a, 32'd15);

    // mixed random traffic with random consumer stalls
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [31:0] ins;
      logic [5:0]  ops [12];
      logic [5:0]  fns [20];
      ops = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h23, 6'h2B, 6'h02};
      fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
              6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h18, 6'h05, 6'h2A};
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 11)];
      ins[25:21] = 5'd0;
      ins[20:16] = 5'($urandom_range(0, 2));
      if (ins[31:26] == 6'h00) begin
        ins[15:11] = 5'($urandom_range(0, 2));
        ins[5:0]   = fns[$urandom_range(0, 19)];
      end
      push(ins);
    end
    rand_rdy = 1'b0;
    #2;
    out_ready = 1'b1;
    drain();

    // reset while one record is pending and three are queued
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) push(itype(6'h09, 5'd0, 5'd1, 16'h0100));
    @(posedge clk); #1;
    check("t6_pre_valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    ma = INIT_A; mb = INIT_B;
    check("t6_out_valid", {31'b0, out_valid}, 32'd0);
    check("t6_in_ready",  {31'b0, in_ready}, 32'd1);
    check("t6_reg_a",     reg_a, INIT_A);
    check("t6_reg_b",     reg_b, INIT_B);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t6_quiet_valid", {31'b0, out_valid}, 32'd0);
    check("t6_quiet_reg_b", reg_b, INIT_B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
